servo_pwm_array: RTL and testbench

Parametrised N-channel hobby-servo PWM generator with per-channel slew limiting and a valid/ready command port; successor to the fixed three-channel arm/theta/motor PWM controller. Sits between the launcher control logic (fire/angle/velocity decode or processor-mapped registers) and the servo/ESC output pins. All channels share one frame counter so pulses are phase-aligned. Width changes are applied only at frame boundaries, and each change is rate-limited.

---
 rtl/servo_pwm_array.sv | 109 ++++++++++
 tb/tb_servo_pwm_array.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_array.sv
// N-channel hobby-servo PWM generator sharing one frame counter; each channel's
// applied width follows its commanded target, rate-limited and updated only at frame ends.
module servo_pwm_array #(
  parameter int NUM_CH        = 3,
  parameter int PERIOD_CYCLES = 1000000,
  parameter int MIN_PULSE     = 50000,
  parameter int MAX_PULSE     = 100000,
  parameter int STEP_CYCLES   = 196,
  parameter int CMD_W         = 8,
  parameter int SLEW_STEP     = 2500,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [CH_W-1:0]   cmd_ch_i,
  input  logic [CMD_W-1:0]  cmd_value_i,
  output logic [NUM_CH-1:0] pwm_out_o,
  output logic [NUM_CH-1:0] settled_o,
  output logic              frame_start_o,
  output logic              cmd_error_o
);

  localparam int CNT_W = $clog2(PERIOD_CYCLES);
  localparam int W_W   = $clog2(MAX_PULSE + 1);
  localparam int CMP_W = (CNT_W > W_W) ? CNT_W : W_W;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [W_W-1:0]   CENTER = W_W'((MIN_PULSE + MAX_PULSE) / 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_f_q, en_f_d;
  logic             cmd_error_q, cmd_error_d;
  logic             boundary;
  logic             accept;
  logic             ch_ok;
  logic [63:0]      w_wide;
  logic [W_W-1:0]   w_cmd;

  // Refusing commands in the boundary cycle keeps target writes and slew updates disjoint.
  assign cmd_ready_o   = !reset_i && !boundary;
  assign frame_start_o = (cnt_q == '0);
  assign cmd_error_o   = cmd_error_q;

  always_comb begin
    boundary    = (cnt_q == LAST);
    accept      = cmd_valid_i && cmd_ready_o;
    ch_ok       = (int'(cmd_ch_i) < NUM_CH);
    w_wide      = 64'(MIN_PULSE) + 64'(cmd_value_i) * 64'(STEP_CYCLES);
    w_cmd       = (w_wide > 64'(MAX_PULSE)) ? W_W'(MAX_PULSE) : w_wide[W_W-1:0];
    cnt_d       = boundary ? '0 : cnt_q + CNT_W'(1);
    en_f_d      = boundary ? enable_i : en_f_q;
    cmd_error_d = cmd_error_q | (accept & ~ch_ok);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q       <= '0;
      en_f_q      <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      en_f_q      <= en_f_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [W_W-1:0] tgt_q, tgt_d;
    logic [W_W-1:0] cur_q, cur_d;
    logic           pwm_q, pwm_d;

    always_comb begin
      tgt_d = tgt_q;
      if (accept && ch_ok && (int'(cmd_ch_i) == gi)) begin
        tgt_d = w_cmd;
      end
      cur_d = cur_q;
      if (boundary) begin
        if (tgt_q >= cur_q) begin
          if (int'(tgt_q - cur_q) <= SLEW_STEP) cur_d = tgt_q;
          else                                   cur_d = cur_q + W_W'(SLEW_STEP);
        end else begin
          if (int'(cur_q - tgt_q) <= SLEW_STEP) cur_d = tgt_q;
          else                                   cur_d = cur_q - W_W'(SLEW_STEP);
        end
      end
      // High for exactly cur cycles, starting the cycle after frame_start.
      pwm_d = en_f_q && (CMP_W'(cnt_q) < CMP_W'(cur_q));
    end

    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        tgt_q <= CENTER;
        cur_q <= CENTER;
        pwm_q <= 1'b0;
      end else begin
        tgt_q <= tgt_d;
        cur_q <= cur_d;
        pwm_q <= pwm_d;
      end
    end

    assign pwm_out_o[gi] = pwm_q;
    assign settled_o[gi] = (cur_q == tgt_q);
  end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Bench for servo_pwm_array: frame-level reference model checked every cycle,
// plus per-frame pulse-width measurements pinned to hand-computed values.
module tb_servo_pwm_array;

  localparam int NCH  = 3;
  localparam int PER  = 100;
  localparam int MINP = 10;
  localparam int MAXP = 40;
  localparam int SLEW = 5;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       enable = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_ch = 2'd0;
  logic [7:0] cmd_value = 8'd0;
  logic       cmd_ready;
  logic [2:0] pwm;
  logic [2:0] settled;
  logic       frame_start;
  logic       cmd_error;

  int n_checks = 0;
  int n_fail = 0;
  bit started = 1'b0;

  // Reference model state: position in frame, per-frame enable, targets, applied widths.
  int m_pos = 0;
  bit m_en = 1'b0;
  bit m_err = 1'b0;
  int m_tgt[NCH] = '{25, 25, 25};
  int m_cur[NCH] = '{25, 25, 25};

  servo_pwm_array #(
    .NUM_CH(NCH), .PERIOD_CYCLES(PER), .MIN_PULSE(MINP), .MAX_PULSE(MAXP),
    .STEP_CYCLES(1), .CMD_W(8), .SLEW_STEP(SLEW)
  ) dut (
    .clock_i(clk), .reset_i(reset_i), .enable_i(enable),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_ch_i(cmd_ch), .cmd_value_i(cmd_value),
    .pwm_out_o(pwm), .settled_o(settled),
    .frame_start_o(frame_start), .cmd_error_o(cmd_error)
  );

  always #5 clk = ~clk;

  function automatic int cmd_w(int v);
    int w;
    w = MINP + v;
    return (w > MAXP) ? MAXP : w;
  endfunction

  function automatic int slew(int c, int t);
    if (t - c > SLEW) return c + SLEW;
    if (c - t > SLEW) return c - SLEW;
    return t;
  endfunction

  always @(posedge clk) begin
    if (reset_i) begin
      m_pos <= 0;
      m_en  <= 1'b0;
      m_err <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_tgt[i] <= 25;
        m_cur[i] <= 25;
      end
    end else begin
      if (cmd_valid && m_pos != PER - 1) begin
        if (int'(cmd_ch) < NCH) m_tgt[int'(cmd_ch)] <= cmd_w(int'(cmd_value));
        else                    m_err <= 1'b1;
      end
      if (m_pos == PER - 1) begin
        m_pos <= 0;
        m_en  <= enable;
        for (int i = 0; i < NCH; i++) m_cur[i] <= slew(m_cur[i], m_tgt[i]);
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  logic [2:0] exp_pwm, exp_set;
  always begin
    @(negedge clk);
    #1;
    if (started) begin
      for (int i = 0; i < NCH; i++) begin
        exp_pwm[i] = m_en && (m_pos >= 1) && (m_pos <= m_cur[i]);
        exp_set[i] = (m_cur[i] == m_tgt[i]);
      end
      check("pwm_out", int'(pwm), int'(exp_pwm));
      check("settled", int'(settled), int'(exp_set));
      check("frame_start", int'(frame_start), int'(m_pos == 0));
      check("cmd_ready", int'(cmd_ready), int'(!reset_i && m_pos != PER - 1));
      check("cmd_error", int'(cmd_error), int'(m_err));
    end
  end

  // Runs one whole frame (positions 0..PER-1), applying the stimulus of the given mode
  // and measuring each channel's high-cycle count and first high position.
  task automatic run_frame(input int mode, input int ch, input int val,
                           output int w[NCH], output int fh[NCH],
                           output int acc, output int rdy_low);
    int guard;
    guard = 0;
    acc = 0;
    rdy_low = 0;
    for (int i = 0; i < NCH; i++) begin
      w[i] = 0;
      fh[i] = -1;
    end
    while (m_pos != 0 && guard < 3 * PER) begin
      @(negedge clk);
      guard++;
    end
    if (m_pos != 0) check("frame_align_timeout", m_pos, 0);
    for (int p = 0; p < PER; p++) begin
      if (p > 0) @(negedge clk);
      case (mode)
        1: begin cmd_valid = (p == 10); cmd_ch = 2'(ch); cmd_value = 8'(val); end
        2: begin cmd_valid = 1'b1; cmd_ch = 2'(ch); cmd_value = 8'(p % 31); end
        3: begin cmd_valid = 1'b0; if (p == 50) enable = 1'b0; end
        4: begin cmd_valid = 1'b0; if (p == 50) enable = 1'b1; end
        default: cmd_valid = 1'b0;
      endcase
      if (cmd_valid && cmd_ready) acc++;
      if (!cmd_ready) rdy_low++;
      for (int i = 0; i < NCH; i++) begin
        if (pwm[i]) begin
          w[i]++;
          if (fh[i] < 0) fh[i] = p;
        end
      end
    end
  endtask

  task automatic chk_w(input string tag, input int w[NCH], input int e0, input int e1, input int e2);
    check($sformatf("%s_w0", tag), w[0], e0);
    check($sformatf("%s_w1", tag), w[1], e1);
    check($sformatf("%s_w2", tag), w[2], e2);
    $display("frame %s: widths %0d %0d %0d", tag, w[0], w[1], w[2]);
  endtask

  task automatic wait_pos(input int p);
    int guard;
    guard = 0;
    @(negedge clk);
    while (m_pos != p && guard < 3 * PER) begin
      @(negedge clk);
      guard++;
    end
    if (m_pos != p) check("wait_pos_timeout", m_pos, p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w[NCH];
    int fh[NCH];
    int acc;
    int rl;

    // Reset state
    @(negedge clk);
    started = 1'b1;
    check("rst_pwm", int'(pwm), 0);
    check("rst_settled", int'(settled), 7);
    check("rst_ready", int'(cmd_ready), 0);
    check("rst_frame_start", int'(frame_start), 1);
    check("rst_cmd_error", int'(cmd_error), 0);
    @(negedge clk);
    reset_i = 1'b0;

    // 1: idle, centre width once enabled
    run_frame(0, 0, 0, w, fh, acc, rl); chk_w("t1_f0", w, 0, 0, 0);
    run_frame(0, 0, 0, w, fh, acc, rl); chk_w("t1_f1", w, 25, 25, 25);
    check("t1_rise_pos", fh[0], 1);
    check("t1_settled", int'(settled), 7);

    // 2: ch1 -> 40, slewing 30, 35, 40
    run_frame(1, 1, 30, w, fh, acc, rl); chk_w("t2_cmd", w, 25, 25, 25);
    check("t2_settled_pending", int'(settled), 5);
    run_frame(0, 0, 0, w, fh, acc, rl); chk_w("t2_a", w, 25, 30, 25);
    run_frame(0, 0, 0, w, fh, acc, rl); chk_w("t2_b", w, 25, 35, 25);
    check("t2_settled_late", int'(settled), 5);
    run_frame(0, 0, 0, w, fh, acc, rl); chk_w("t2_c", w, 25, 40, 25);
    check("t2_rise_pos", fh[1], 1);
    check("t2_settled_done", int'(settled), 7);

    // 3: ch2 clamps to 40, then retargeted to 10 mid-slew
    run_frame(1, 2, 200, w, fh, acc, rl); chk_w("t3_cmd", w, 25, 40, 25);
    run_frame(1, 2, 0, w, fh, acc, rl);   chk_w("t3_a", w, 25, 40, 30);
    run_frame(0, 0, 0, w, fh, acc, rl);   chk_w("t3_b", w, 25, 40, 25);
    run_frame(0, 0, 0, w, fh, acc, rl);   chk_w("t3_c", w, 25, 40, 20);
    run_frame(0, 0, 0, w, fh, acc, rl);   chk_w("t3_d", w, 25, 40, 15);
    run_frame(0, 0, 0, w, fh, acc, rl);   chk_w("t3_e", w, 25, 40, 10);

    // 4: continuous valid on ch0; last accepted value (98 % 31 = 5) gives tgt 15
    run_frame(2, 0, 0, w, fh, acc, rl);   chk_w("t4_hold", w, 25, 40, 10);
    check("t4_accepts", acc, 99);
    check("t4_ready_low", rl, 1);
    run_frame(0, 0, 0, w, fh, acc, rl);   chk_w("t4_a", w, 20, 40, 10);
    run_frame(0, 0, 0, w, fh, acc, rl);   chk_w("t4_b", w, 15, 40, 10);
    check("t4_settled", int'(settled), 7);

    // 5: out-of-range channel
    run_frame(1, 3, 5, w, fh, acc, rl);   chk_w("t5_cmd", w, 15, 40, 10);
    check("t5_error", int'(cmd_error), 1);
    check("t5_settled", int'(settled), 7);
    run_frame(0, 0, 0, w, fh, acc, rl);   chk_w("t5_after", w, 15, 40, 10);
    check("t5_error_sticky", int'(cmd_error), 1);

    // 6: enable drop mid-frame, then reset during an active pulse
    run_frame(3, 0, 0, w, fh, acc, rl);   chk_w("t6_drop", w, 15, 40, 10);
    run_frame(4, 0, 0, w, fh, acc, rl);   chk_w("t6_off", w, 0, 0, 0);
    run_frame(0, 0, 0, w, fh, acc, rl);   chk_w("t6_resume", w, 15, 40, 10);
    wait_pos(5);
    check("t6_pulse_active", int'(pwm), 7);
    reset_i = 1'b1;
    @(negedge clk);
    check("t6_rst_pwm", int'(pwm), 0);
    check("t6_rst_error", int'(cmd_error), 0);
    check("t6_rst_frame_start", int'(frame_start), 1);
    @(negedge clk);
    reset_i = 1'b0;
    run_frame(0, 0, 0, w, fh, acc, rl);   chk_w("t6_post0", w, 0, 0, 0);
    run_frame(0, 0, 0, w, fh, acc, rl);   chk_w("t6_post1", w, 25, 25, 25);
    check("t6_post_error", int'(cmd_error), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
